// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between the CPU inst and data ports, holds a
// granted request until accepted, and steers in-order responses via an owner FIFO.
//
// state     | meaning
// ST_IDLE   | combinational grant, data favoured unless inst streak limit reached
// ST_HOLD_I | inst granted but not yet accepted, grant pinned to inst
// ST_HOLD_D | data granted but not yet accepted, grant pinned to data
module mem_req_arbiter #(
   parameter int OUTSTANDING = 4,
   parameter int MAX_STREAK  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   input  logic        inst_uncached,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic        data_uncached,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_uncached,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic        err_unexpected
);

   localparam int PW = $clog2(OUTSTANDING);
   localparam int SW = $clog2(MAX_STREAK + 1);
   localparam logic [PW:0]   FULL_CNT   = OUTSTANDING[PW:0];
   localparam logic [SW-1:0] STREAK_MAX = MAX_STREAK[SW-1:0];

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD_I, ST_HOLD_D} state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]            count_q, count_d;
   logic [OUTSTANDING-1:0] owner_q, owner_d;
   logic [SW-1:0]          streak_q, streak_d;
   logic                   err_q, err_d;

   logic gnt_vld, gnt_data, fifo_full, accept, pop, head_data;

   assign fifo_full = (count_q == FULL_CNT);

   always_comb begin
      gnt_vld  = 1'b0;
      gnt_data = 1'b0;
      case (state_q)
         ST_HOLD_I: gnt_vld = inst_req;
         ST_HOLD_D: begin
            gnt_vld  = data_req;
            gnt_data = 1'b1;
         end
         default: begin
            if (!fifo_full) begin
               if (streak_q == STREAK_MAX && inst_req) begin
                  gnt_vld = 1'b1;
               end else if (data_req) begin
                  gnt_vld  = 1'b1;
                  gnt_data = 1'b1;
               end else if (inst_req) begin
                  gnt_vld = 1'b1;
               end
            end
         end
      endcase
   end

   assign mem_req      = gnt_vld & ~fifo_full & ~rst;
   assign accept       = mem_req & mem_addr_ok;
   assign mem_wr       = gnt_data ? data_wr       : inst_wr;
   assign mem_size     = gnt_data ? data_size     : inst_size;
   assign mem_addr     = gnt_data ? data_addr     : inst_addr;
   assign mem_wdata    = gnt_data ? data_wdata    : inst_wdata;
   assign mem_uncached = gnt_data ? data_uncached : inst_uncached;
   assign inst_addr_ok = accept & ~gnt_data;
   assign data_addr_ok = accept & gnt_data;

   // A response with nothing outstanding is flagged but never steered to a port.
   assign pop          = mem_data_ok & (count_q != '0) & ~rst;
   assign head_data    = owner_q[rd_ptr_q];
   assign inst_data_ok = pop & ~head_data;
   assign data_data_ok = pop & head_data;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;
   assign err_unexpected = err_q;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      owner_d  = owner_q;
      streak_d = streak_q;
      err_d    = err_q | (mem_data_ok & (count_q == '0));

      case (state_q)
         ST_IDLE: begin
            if (mem_req && !mem_addr_ok) begin
               state_d = gnt_data ? ST_HOLD_D : ST_HOLD_I;
            end
         end
         default: begin
            if (!gnt_vld || mem_addr_ok) begin
               state_d = ST_IDLE;
            end
         end
      endcase

      if (accept) begin
         owner_d[wr_ptr_q] = gnt_data;
         wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({accept, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (!inst_req || (accept && !gnt_data)) begin
         streak_d = '0;
      end else if (accept && gnt_data && streak_q != STREAK_MAX) begin
         streak_d = streak_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         owner_q  <= '0;
         streak_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_mem_req_arbiter;

   localparam int OUTSTANDING = 4;
   localparam int MAX_STREAK  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wr, inst_uncached;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr, data_uncached;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr, mem_uncached;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;
   logic        err_unexpected;

   mem_req_arbiter #(.OUTSTANDING(OUTSTANDING), .MAX_STREAK(MAX_STREAK)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_uncached(inst_uncached), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_uncached(data_uncached), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_uncached(mem_uncached), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_unexpected(err_unexpected)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: owners of outstanding transactions (0=inst, 1=data)
   bit q_owner[$];
   int held;            // port whose unaccepted grant is pinned: 0 none, 1 inst, 2 data
   int streak;
   bit m_err;

   bit e_mem_req, e_iaok, e_daok, e_idok, e_ddok, e_pop, e_err_set;
   int g_last;
   bit prev_i_acc, prev_d_acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q_owner.delete();
      held   = 0;
      streak = 0;
      m_err  = 1'b0;
   endtask

   task automatic eval_cmp();
      bit full;
      int g;
      full = (q_owner.size() == OUTSTANDING);
      g = 0;
      if (held == 1)      g = inst_req ? 1 : 0;
      else if (held == 2) g = data_req ? 2 : 0;
      else if (!full) begin
         if (streak == MAX_STREAK && inst_req) g = 1;
         else if (data_req)                   g = 2;
         else if (inst_req)                   g = 1;
      end
      e_mem_req = (g != 0) && !full && !rst;
      e_iaok    = e_mem_req && mem_addr_ok && g == 1;
      e_daok    = e_mem_req && mem_addr_ok && g == 2;
      e_pop     = mem_data_ok && q_owner.size() > 0 && !rst;
      e_idok    = e_pop && q_owner[0] == 1'b0;
      e_ddok    = e_pop && q_owner[0] == 1'b1;
      e_err_set = mem_data_ok && q_owner.size() == 0;
      g_last    = g;
      chk("mem_req", mem_req, e_mem_req);
      chk("inst_addr_ok", inst_addr_ok, e_iaok);
      chk("data_addr_ok", data_addr_ok, e_daok);
      chk("inst_data_ok", inst_data_ok, e_idok);
      chk("data_data_ok", data_data_ok, e_ddok);
      chk("err_unexpected", err_unexpected, m_err);
      if (e_mem_req && mem_req) begin
         chk("mem_addr",     mem_addr,     g == 2 ? data_addr     : inst_addr);
         chk("mem_wdata",    mem_wdata,    g == 2 ? data_wdata    : inst_wdata);
         chk("mem_size",     mem_size,     g == 2 ? data_size     : inst_size);
         chk("mem_wr",       mem_wr,       g == 2 ? data_wr       : inst_wr);
         chk("mem_uncached", mem_uncached, g == 2 ? data_uncached : inst_uncached);
      end
      if (e_idok) chk("inst_rdata", inst_rdata, mem_rdata);
      if (e_ddok) chk("data_rdata", data_rdata, mem_rdata);
   endtask

   task automatic tick();
      @(negedge clk);
      eval_cmp();
   endtask

   task automatic adv();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (e_pop) void'(q_owner.pop_front());
         if (e_iaok) q_owner.push_back(1'b0);
         if (e_daok) q_owner.push_back(1'b1);
         if (e_err_set) m_err = 1'b1;
         if (!inst_req || e_iaok) streak = 0;
         else if (e_daok && streak < MAX_STREAK) streak++;
         held = (e_mem_req && !mem_addr_ok) ? g_last : 0;
      end
      prev_i_acc = e_iaok;
      prev_d_acc = e_daok;
      #1;
   endtask

   task automatic new_inst();
      inst_wr       = 1'($urandom_range(0, 1));
      inst_size     = 2'($urandom_range(0, 2));
      inst_addr     = $urandom;
      inst_wdata    = $urandom;
      inst_uncached = 1'($urandom_range(0, 1));
   endtask

   task automatic new_data();
      data_wr       = 1'($urandom_range(0, 1));
      data_size     = 2'($urandom_range(0, 2));
      data_addr     = $urandom;
      data_wdata    = $urandom;
      data_uncached = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      inst_req = 1'b0;
      data_req = 1'b0;
      mem_addr_ok = 1'b0;
      while (q_owner.size() > 0 && guard < 50) begin
         mem_data_ok = 1'b1;
         mem_rdata   = $urandom;
         tick();
         adv();
         guard++;
      end
      if (guard >= 50) chk("drain_timeout", 32'(guard), 32'd0);
      mem_data_ok = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0; inst_uncached = 0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0; data_uncached = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
      model_reset();
      prev_i_acc = 0; prev_d_acc = 0;

      tick();
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_err", err_unexpected, 1'b0);
      adv();
      rst = 1'b0;

      // data wins a simultaneous request, inst follows
      inst_req = 1; inst_addr = 32'h1000;
      data_req = 1; data_addr = 32'h2000;
      mem_addr_ok = 1;
      tick();
      chk("t1_addr_d", mem_addr, 32'h2000);
      chk("t1_daok", data_addr_ok, 1'b1);
      adv();
      data_req = 0;
      tick();
      chk("t1_addr_i", mem_addr, 32'h1000);
      chk("t1_iaok", inst_addr_ok, 1'b1);
      adv();
      drain();

      // streak limit forces inst in after four data grants
      inst_req = 1; data_req = 1; mem_addr_ok = 1;
      for (int i = 0; i < 6; i++) begin
         mem_data_ok = (q_owner.size() > 0);
         mem_rdata   = $urandom;
         tick();
         chk("t2_iaok", inst_addr_ok, (i == 4) ? 1'b1 : 1'b0);
         chk("t2_daok", data_addr_ok, (i == 4) ? 1'b0 : 1'b1);
         adv();
      end
      drain();

      // held data grant survives inst arriving during the stall
      data_req = 1; data_addr = 32'h2000; inst_req = 0; mem_addr_ok = 0;
      tick();
      chk("t3_addr0", mem_addr, 32'h2000);
      adv();
      inst_req = 1; inst_addr = 32'h1000;
      for (int i = 1; i < 3; i++) begin
         tick();
         chk("t3_addr_hold", mem_addr, 32'h2000);
         chk("t3_mem_req", mem_req, 1'b1);
         adv();
      end
      mem_addr_ok = 1;
      tick();
      chk("t3_daok", data_addr_ok, 1'b1);
      chk("t3_addr3", mem_addr, 32'h2000);
      adv();
      data_req = 0;
      tick();
      chk("t3_iaok", inst_addr_ok, 1'b1);
      chk("t3_addr4", mem_addr, 32'h1000);
      adv();
      drain();

      // response routing and full-FIFO backpressure
      mem_addr_ok = 1;
      for (int k = 0; k < 4; k++) begin
         inst_req = (k % 2 == 0);
         data_req = !inst_req;
         tick();
         chk("t4_accept", {inst_addr_ok, data_addr_ok}, (k % 2 == 0) ? 2'b10 : 2'b01);
         adv();
      end
      inst_req = 1; data_req = 0;
      tick();
      chk("t4_full_req", mem_req, 1'b0);
      adv();
      for (int k = 0; k < 5; k++) begin
         mem_data_ok = 1;
         mem_rdata   = 32'hA + 32'(k);
         tick();
         chk("t4_idok", inst_data_ok, (k % 2 == 0) ? 1'b1 : 1'b0);
         chk("t4_ddok", data_data_ok, (k % 2 == 0) ? 1'b0 : 1'b1);
         if (k % 2 == 0) chk("t4_irdata", inst_rdata, 32'hA + 32'(k));
         else            chk("t4_drdata", data_rdata, 32'hA + 32'(k));
         if (k == 0) chk("t4_no_bypass", mem_req, 1'b0);
         if (k == 1) chk("t4_fifth_acc", inst_addr_ok, 1'b1);
         adv();
         if (k == 1) inst_req = 0;
      end
      mem_data_ok = 0;

      // async reset while holding inst with two outstanding
      mem_addr_ok = 1;
      inst_req = 1; data_req = 0; tick(); adv();
      inst_req = 0; data_req = 1; tick(); adv();
      data_req = 0; inst_req = 1; mem_addr_ok = 0;
      tick(); adv();
      #2 rst = 1;
      #1 chk("t6_req_in_rst", mem_req, 1'b0);
      model_reset();
      mem_addr_ok = 1; mem_data_ok = 1;
      tick();
      adv();
      rst = 0;
      mem_data_ok = 0; data_req = 1;
      tick();
      chk("t6_idle_daok", data_addr_ok, 1'b1);
      chk("t6_err", err_unexpected, 1'b0);
      adv();
      data_req = 0;
      tick(); adv();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      tick();
      chk("t6_head_data", data_data_ok, 1'b1);
      adv();
      tick();
      chk("t6_head_inst", inst_data_ok, 1'b1);
      adv();

      // response with nothing outstanding
      mem_data_ok = 1;
      tick();
      chk("t5_no_idok", inst_data_ok, 1'b0);
      chk("t5_no_ddok", data_data_ok, 1'b0);
      adv();
      mem_data_ok = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_err_sticky", err_unexpected, 1'b1);
         adv();
      end
      rst = 1;
      model_reset();
      tick();
      chk("t5_err_clr", err_unexpected, 1'b0);
      adv();
      rst = 0;

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (inst_req) begin
            if (prev_i_acc) begin
               inst_req = 1'($urandom_range(0, 1));
               if (inst_req) new_inst();
            end else if ($urandom_range(0, 63) == 0) inst_req = 0;
         end else if ($urandom_range(0, 2) == 0) begin
            inst_req = 1;
            new_inst();
         end
         if (data_req) begin
            if (prev_d_acc) begin
               data_req = 1'($urandom_range(0, 1));
               if (data_req) new_data();
            end else if ($urandom_range(0, 63) == 0) data_req = 0;
         end else if ($urandom_range(0, 2) == 0) begin
            data_req = 1;
            new_data();
         end
         mem_addr_ok = ($urandom_range(0, 99) < 60);
         mem_data_ok = (q_owner.size() > 0) && ($urandom_range(0, 1) == 1);
         mem_rdata   = $urandom;
         tick();
         adv();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
